// File: rtl/seg7_scan.sv
// Six-digit multiplexed 7-segment driver for an HH:MM:SS display. Each digit slot opens
// with a blank guard cycle. Set-mode blink is per field, and the hours tens digit can be blanked.
module seg7_scan #(
  parameter int unsigned SCAN_DIV   = 4,
  parameter int unsigned BLINK_HALF = 500
) (
  input  logic       CLK1K,
  input  logic       RST,
  input  logic [7:0] BCD_S,
  input  logic [7:0] BCD_M,
  input  logic [7:0] BCD_H,
  input  logic [2:0] BLINK,
  input  logic       COLON,
  input  logic       LZB,
  output logic [6:0] SEG,
  output logic       DP,
  output logic [5:0] COM
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BlkW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic [BlkW-1:0] blk_cnt_q, blk_cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic            phase_q, phase_d;
  logic [6:0]      seg_d;
  logic            dp_d;
  logic [5:0]      com_d;

  logic            div_wrap, blk_wrap;
  logic [3:0]      nibble;
  logic [6:0]      glyph;
  logic            field_blink, blank;

  // Scan and blink counters
  always_comb begin
    div_wrap  = (div_cnt_q == DivW'(SCAN_DIV - 1));
    blk_wrap  = (blk_cnt_q == BlkW'(BLINK_HALF - 1));
    div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
    idx_d     = idx_q;
    if (div_wrap) begin
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end
    blk_cnt_d = blk_wrap ? '0 : blk_cnt_q + 1'b1;
    phase_d   = blk_wrap ? ~phase_q : phase_q;
  end

  // Digit select, decode and blanking from the current (pre-edge) slot
  always_comb begin
    nibble = 4'h0;
    case (idx_q)
      3'd0:    nibble = BCD_S[3:0];
      3'd1:    nibble = BCD_S[7:4];
      3'd2:    nibble = BCD_M[3:0];
      3'd3:    nibble = BCD_M[7:4];
      3'd4:    nibble = BCD_H[3:0];
      3'd5:    nibble = BCD_H[7:4];
      default: nibble = 4'h0;
    endcase

    case (nibble)
      4'd0:    glyph = 7'b0111111;
      4'd1:    glyph = 7'b0000110;
      4'd2:    glyph = 7'b1011011;
      4'd3:    glyph = 7'b1001111;
      4'd4:    glyph = 7'b1100110;
      4'd5:    glyph = 7'b1101101;
      4'd6:    glyph = 7'b1111101;
      4'd7:    glyph = 7'b0000111;
      4'd8:    glyph = 7'b1111111;
      4'd9:    glyph = 7'b1101111;
      default: glyph = 7'b1111001;  // non-BCD shows 'E'
    endcase

    case (idx_q[2:1])
      2'd0:    field_blink = BLINK[0];
      2'd1:    field_blink = BLINK[1];
      default: field_blink = BLINK[2];
    endcase

    blank = (field_blink && !phase_q) ||
            ((idx_q == 3'd5) && LZB && (BCD_H[7:4] == 4'h0));

    seg_d = 7'b0;
    dp_d  = 1'b0;
    com_d = 6'b0;
    if (div_cnt_q != '0) begin
      com_d = 6'b000001 << idx_q;
      if (!blank) begin
        seg_d = glyph;
        dp_d  = COLON && ((idx_q == 3'd2) || (idx_q == 3'd4));
      end
    end
  end

  always_ff @(posedge CLK1K) begin
    if (RST) begin
      div_cnt_q <= '0;
      idx_q     <= 3'd0;
      blk_cnt_q <= '0;
      phase_q   <= 1'b1;
      SEG       <= 7'b0;
      DP        <= 1'b0;
      COM       <= 6'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      blk_cnt_q <= blk_cnt_d;
      phase_q   <= phase_d;
      SEG       <= seg_d;
      DP        <= dp_d;
      COM       <= com_d;
    end
  end

endmodule
